// File: rtl/rf_alu_dm_seq_if.sv
// Instruction/debug bundle between the decoder and the multi-cycle datapath.
// Master drives a pre-decoded instruction under valid/ready; slave returns status and debug reads.
interface rf_alu_dm_seq_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        ALUOp;
    logic [10:0]       OpCodefield;
    logic [4:0]        Rn;
    logic [4:0]        Rm;
    logic [4:0]        Rt;
    logic [8:0]        DispIn;
    logic              RegWrite;
    logic              MemRead;
    logic              MemWrite;
    logic              ALUSrc_Select;
    logic              MemtoReg_Select;
    logic              Reg2Loc_Select;
    logic              done;
    logic [1:0]        err_code;
    logic              Zero;
    logic              dbg_we;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (
        output in_valid, ALUOp, OpCodefield, Rn, Rm, Rt, DispIn,
               RegWrite, MemRead, MemWrite, ALUSrc_Select, MemtoReg_Select, Reg2Loc_Select,
               dbg_we, dbg_addr, dbg_wdata,
        input  in_ready, done, err_code, Zero, dbg_rdata
    );

    modport slave (
        input  in_valid, ALUOp, OpCodefield, Rn, Rm, Rt, DispIn,
               RegWrite, MemRead, MemWrite, ALUSrc_Select, MemtoReg_Select, Reg2Loc_Select,
               dbg_we, dbg_addr, dbg_wdata,
        output in_ready, done, err_code, Zero, dbg_rdata
    );
endinterface

// File: rtl/rf_alu_dm_seq.sv
// Multi-cycle LEGv8 RF/ALU/DM datapath; 3-5 cycles accept-to-done depending on mem/writeback.
// One instruction in flight: in_ready is low from acceptance until the FSM returns to IDLE.
module rf_alu_dm_seq #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int DM_DEPTH = 256,
    parameter int ZERO_REG = 1
) (
    input logic               clock,
    input logic               reset_n,
    rf_alu_dm_seq_if.slave    bus
);
    localparam int AW  = $clog2(NREGS);
    localparam int BW  = $clog2(DATA_W / 8);
    localparam int DMW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_MEM, S_WB} state_t;

    state_t state, nxt;

    logic [DATA_W-1:0] rf [NREGS];
    logic [DATA_W-1:0] dm [DM_DEPTH];

    logic [1:0]        aluop_q;
    logic [10:0]       opc_q;
    logic [AW-1:0]     rn_q, rm_q, rt_q;
    logic [8:0]        disp_q;
    logic              rw_q, mr_q, mw_q, alusrc_q, mtr_q, r2l_q;

    logic [DATA_W-1:0] a_q, b_q, sd_q, alu_q, md_q;
    logic [1:0]        err_q;
    logic              zero_q, done_q;

    logic              accept, done_d, misalign, mem_ok, wb_we, dbg_wr;
    logic [1:0]        ex_err, mem_err;
    logic [DATA_W-1:0] op2, alu_res, widx_full;
    logic [DMW-1:0]    dm_idx;
    logic [AW-1:0]     dbg_idx, b_idx;
    logic              unused_widx_hi;

    function automatic logic is_zr(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (int'(idx) == NREGS - 1);
    endfunction

    assign accept  = bus.in_valid && (state == S_IDLE);
    assign dbg_idx = bus.dbg_addr[AW-1:0];
    assign b_idx   = r2l_q ? rt_q : rm_q;

    // EX: operand select and ALU; non-R-type ALUOp values never flag an error
    always_comb begin
        op2     = alusrc_q ? {{(DATA_W-9){disp_q[8]}}, disp_q} : b_q;
        alu_res = '0;
        ex_err  = 2'b00;
        case (aluop_q)
            2'b01: alu_res = op2;
            2'b10: begin
                case (opc_q)
                    OP_ADD:  alu_res = a_q + op2;
                    OP_SUB:  alu_res = a_q - op2;
                    OP_AND:  alu_res = a_q & op2;
                    OP_ORR:  alu_res = a_q | op2;
                    default: ex_err  = 2'b01;
                endcase
            end
            default: alu_res = a_q + op2;
        endcase
    end

    // MEM: byte address to word index, wrapping address bits beyond the memory depth
    assign misalign       = |alu_q[BW-1:0];
    assign mem_ok         = (err_q == 2'b00) && !misalign;
    assign mem_err        = (err_q != 2'b00) ? err_q : (misalign ? 2'b10 : 2'b00);
    assign widx_full      = (alu_q >> BW) % DATA_W'(DM_DEPTH);
    assign dm_idx         = widx_full[DMW-1:0];
    assign unused_widx_hi = ^widx_full[DATA_W-1:DMW];

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (accept) nxt = S_RD;
            S_RD:   nxt = S_EX;
            S_EX: begin
                if (mr_q || mw_q)                   nxt = S_MEM;
                else if (rw_q && ex_err == 2'b00)   nxt = S_WB;
                else                                nxt = S_IDLE;
            end
            S_MEM:  nxt = (rw_q && mem_err == 2'b00) ? S_WB : S_IDLE;
            S_WB:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    assign done_d = (state != S_IDLE) && (nxt == S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            done_q   <= 1'b0;
            aluop_q  <= '0;
            opc_q    <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            rt_q     <= '0;
            disp_q   <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            alusrc_q <= 1'b0;
            mtr_q    <= 1'b0;
            r2l_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sd_q     <= '0;
            alu_q    <= '0;
            md_q     <= '0;
            err_q    <= 2'b00;
            zero_q   <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= done_d;
            if (accept) begin
                aluop_q  <= bus.ALUOp;
                opc_q    <= bus.OpCodefield;
                rn_q     <= bus.Rn[AW-1:0];
                rm_q     <= bus.Rm[AW-1:0];
                rt_q     <= bus.Rt[AW-1:0];
                disp_q   <= bus.DispIn;
                rw_q     <= bus.RegWrite;
                mr_q     <= bus.MemRead;
                mw_q     <= bus.MemWrite;
                alusrc_q <= bus.ALUSrc_Select;
                mtr_q    <= bus.MemtoReg_Select;
                r2l_q    <= bus.Reg2Loc_Select;
            end
            if (state == S_RD) begin
                a_q  <= is_zr(rn_q)  ? '0 : rf[rn_q];
                b_q  <= is_zr(b_idx) ? '0 : rf[b_idx];
                sd_q <= is_zr(rt_q)  ? '0 : rf[rt_q];
            end
            if (state == S_EX) begin
                alu_q  <= alu_res;
                err_q  <= ex_err;
                zero_q <= (alu_res == '0);
            end
            if (state == S_MEM) begin
                err_q <= mem_err;
                if (mem_ok && mr_q) md_q <= dm[dm_idx];
            end
        end
    end

    assign wb_we  = (state == S_WB) && (err_q == 2'b00) && !is_zr(rt_q);
    assign dbg_wr = bus.dbg_we && (state == S_IDLE) && !bus.in_valid && !is_zr(dbg_idx);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[rt_q] <= mtr_q ? md_q : alu_q;
        end else if (dbg_wr) begin
            rf[dbg_idx] <= bus.dbg_wdata;
        end
    end

    // Data memory is deliberately not reset; an async reset drops state out of MEM so no write lands
    always_ff @(posedge clock) begin
        if (state == S_MEM && mem_ok && mw_q) dm[dm_idx] <= sd_q;
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.done      = done_q;
    assign bus.err_code  = err_q;
    assign bus.Zero      = zero_q;
    assign bus.dbg_rdata = is_zr(dbg_idx) ? '0 : rf[dbg_idx];
endmodule
